// File: rtl/rtc_mc_pkg.sv
// Shared definitions for the microcontroller bus front-end.
package rtc_mc_pkg;

  localparam int unsigned MC_AW          = 6;
  localparam int unsigned MC_DW          = 32;
  localparam int unsigned MC_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_ACK,
    ST_HOLD
  } mc_state_e;

endpackage

// File: rtl/rtc_mc_sync.sv
// Multi-flop synchronizer for one asynchronous request level, plus a
// registered rising-edge detect whose history flop resets to HIST_RST.
module rtc_mc_sync #(
  parameter int unsigned STAGES   = 2,
  parameter logic        HIST_RST = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              hist_q;
  logic              rise_q;

  // Shift the asynchronous request through the synchronizer chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], req_i};
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
    end
  end

  // Edge detect. The history is frozen at its reset value until the chain
  // has refilled, otherwise the reset-time zeros in the chain would make a
  // strobe already held at reset release look like a fresh edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= HIST_RST;
      rise_q <= 1'b0;
    end else if (fill_q[STAGES-1]) begin
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
    end else begin
      rise_q <= 1'b0;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/rtc_mc_bus_ctrl.sv
// Microcontroller bus front-end: synchronizes async cs/rd/wr strobes,
// issues single-cycle write/read requests and returns a four-phase ack.
// Optional ack-hold timeout enabled by defining RTC_MC_TIMEOUT_EN.
module rtc_mc_bus_ctrl
  import rtc_mc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = MC_TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cs_n,
  input  logic             i_wr_n,
  input  logic             i_rd_n,
  input  logic [MC_AW-1:0] i_mc_addr,
  input  logic [MC_DW-1:0] i_mc_wdata,
  input  logic [MC_DW-1:0] i_rd_data,
  output logic             o_wr_en,
  output logic             o_rd_en,
  output logic [MC_AW-1:0] o_addr,
  output logic [MC_DW-1:0] o_bus_data,
  output logic [MC_DW-1:0] o_mc_rdata,
  output logic             o_mc_ack,
  output logic             o_proto_err,
  output logic             o_timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("rtc_mc_bus_ctrl: SYNC_STAGES must be 2..4");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("rtc_mc_bus_ctrl: RD_LATENCY must be 1..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("rtc_mc_bus_ctrl: TIMEOUT_CYCLES must be 1..65535");
  end

  localparam logic [2:0] RD_LAT3 = 3'(RD_LATENCY);

  mc_state_e        state_q, state_d;
  logic [MC_AW-1:0] addr_q, addr_d;
  logic [MC_DW-1:0] wdata_q, wdata_d;
  logic [MC_DW-1:0] rdata_q, rdata_d;
  logic [2:0]       lat_q, lat_d;
  logic             perr_q, perr_d;

  logic wr_req, rd_req;
  logic wr_lvl, rd_lvl;
  logic wr_rise, rd_rise;

`ifdef RTC_MC_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] tcnt_q, tcnt_d;
  logic        tmo_q, tmo_d;
`endif

  assign wr_req = ~i_cs_n & ~i_wr_n;
  assign rd_req = ~i_cs_n & ~i_rd_n;

  rtc_mc_sync #(
    .STAGES   (SYNC_STAGES),
    .HIST_RST (1'b1)
  ) u_sync_wr (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .req_i   (wr_req),
    .level_o (wr_lvl),
    .rise_o  (wr_rise)
  );

  rtc_mc_sync #(
    .STAGES   (SYNC_STAGES),
    .HIST_RST (1'b1)
  ) u_sync_rd (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .req_i   (rd_req),
    .level_o (rd_lvl),
    .rise_o  (rd_rise)
  );

  // State, captured bus fields and pulse registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      perr_q  <= 1'b0;
`ifdef RTC_MC_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
      perr_q  <= perr_d;
`ifdef RTC_MC_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state, capture and read-latency counting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    perr_d  = 1'b0;
`ifdef RTC_MC_TIMEOUT_EN
    tcnt_d  = '0;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (wr_lvl && rd_lvl) begin
          perr_d  = 1'b1;
          state_d = ST_HOLD;
        end else if (wr_rise) begin
          addr_d  = i_mc_addr;
          wdata_d = i_mc_wdata;
          state_d = ST_WR_ISSUE;
        end else if (rd_rise) begin
          addr_d  = i_mc_addr;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: state_d = ST_ACK;
      ST_RD_ISSUE: begin
        lat_d   = 3'd1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == RD_LAT3) begin
          rdata_d = i_rd_data;
          state_d = ST_ACK;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_ACK: begin
        if (!wr_lvl && !rd_lvl) begin
          state_d = ST_IDLE;
        end
`ifdef RTC_MC_TIMEOUT_EN
        else if (tcnt_q + 16'd1 == TMO_LIM) begin
          tmo_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
`endif
      end
      ST_HOLD: begin
        if (!wr_lvl && !rd_lvl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_wr_en     = (state_q == ST_WR_ISSUE);
  assign o_rd_en     = (state_q == ST_RD_ISSUE);
  assign o_mc_ack    = (state_q == ST_ACK);
  assign o_addr      = addr_q;
  assign o_bus_data  = wdata_q;
  assign o_mc_rdata  = rdata_q;
  assign o_proto_err = perr_q;
`ifdef RTC_MC_TIMEOUT_EN
  assign o_timeout   = tmo_q;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule
